// File: rtl/eth_tx_pkg.sv
// Shared types and helpers for the Ethernet TX frame sender.
//   eth_tx_state_e : frame sender FSM states (IDLE, STREAM, DONE).
//   eth_tx_keep_f  : byte-enable mask for the final beat of a frame.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } eth_tx_state_e;

  // Widest keep mask the helper can return; callers slice it down to
  // their own keep width.
  localparam int unsigned ETH_TX_KEEP_MAX = 128;

  // Keep mask for the last beat of a len-byte frame: the low (len mod
  // keep_w) bits set, or all keep_w bits set when the frame ends on a
  // full beat.
  function automatic logic [ETH_TX_KEEP_MAX-1:0] eth_tx_keep_f(
    input int unsigned len,
    input int unsigned keep_w
  );
    int unsigned rem;
    logic [ETH_TX_KEEP_MAX-1:0] k;
    rem = len % keep_w;
    k   = '0;
    for (int unsigned i = 0; i < ETH_TX_KEEP_MAX; i++) begin
      if (rem == 0) k[i] = (i < keep_w);
      else          k[i] = (i < rem);
    end
    return k;
  endfunction

endpackage

// File: rtl/eth_tx_beat_fifo.sv
// Two-entry beat queue (data, keep, last) between the frame buffer read
// port and the AXI-Stream output.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : push side; in_data/in_keep/in_last carry the beat
//   out_valid/ready : pop side; the head entry drives out_data/keep/last
//   count           : current occupancy (0..2), used by the producer as
//                     read credit
// Handshake: a transfer happens on a clock edge where valid & ready are
// both 1; valid never depends on ready, and the head entry is held
// unchanged while out_valid=1 until it is popped.
module eth_tx_beat_fifo #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data_q [2];
  logic [KEEP_W-1:0] keep_q [2];
  logic [1:0]        last_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Entries are cleared on reset so the stream outputs read as zero.
  assign out_data = data_q[rd_ptr_q];
  assign out_keep = keep_q[rd_ptr_q];
  assign out_last = last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      keep_q[0] <= '0;
      keep_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        keep_q[wr_ptr_q] <= in_keep;
        last_q[wr_ptr_q] <= in_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/eth_tx_frame_sender.sv
// Frame source for the MAC transmit AXI-Stream input, on logic_clk only.
// Software fills a word buffer through the write port, then issues a send
// command with a byte length; the frame leaves as one AXI-Stream packet.
//   logic_clk, logic_rst : clock, synchronous active-high reset
//   wr_v_i/addr/data     : buffer word write (dropped while busy_o=1)
//   send_v_i, send_len_i : send command, length in bytes
//   busy_o               : a frame is streaming
//   done_o               : one-cycle pulse after the tlast handshake
//   err_o                : one-cycle pulse when a command is rejected
//   tx_axis_*            : AXI-Stream master; tuser is tied to 0
// Handshake: a beat transfers on the clock edge where tvalid & tready are
// both 1; once tvalid rises, tdata/tkeep/tlast hold until that edge and
// tvalid does not fall before it.
module eth_tx_frame_sender #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int BUF_WORDS       = 512,
  parameter int ADDR_WIDTH      = $clog2(BUF_WORDS),
  parameter int LEN_WIDTH       = $clog2(BUF_WORDS * AXIS_KEEP_WIDTH) + 1
) (
  input  logic                       logic_clk,
  input  logic                       logic_rst,
  input  logic                       wr_v_i,
  input  logic [ADDR_WIDTH-1:0]      wr_addr_i,
  input  logic [AXIS_DATA_WIDTH-1:0] wr_data_i,
  input  logic                       send_v_i,
  input  logic [LEN_WIDTH-1:0]       send_len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [AXIS_DATA_WIDTH-1:0] tx_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] tx_axis_tkeep,
  output logic                       tx_axis_tvalid,
  input  logic                       tx_axis_tready,
  output logic                       tx_axis_tlast,
  output logic                       tx_axis_tuser
);

  import eth_tx_pkg::*;

  localparam int unsigned MAX_BYTES = BUF_WORDS * AXIS_KEEP_WIDTH;
  localparam int          BEAT_W    = ADDR_WIDTH + 1;

  eth_tx_state_e state_q;
  eth_tx_state_e state_d;

  logic [AXIS_DATA_WIDTH-1:0] mem [BUF_WORDS];

  logic                       busy;
  logic                       wr_en;
  logic                       len_ok;
  logic                       send_accept;
  logic                       send_reject;
  logic [LEN_WIDTH-1:0]       beats_full;
  logic [BEAT_W-1:0]          beats_d;
  logic [AXIS_KEEP_WIDTH-1:0] last_keep_d;
  logic [AXIS_KEEP_WIDTH-1:0] last_keep_q;

  logic [ADDR_WIDTH-1:0]      rd_addr_q;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic [BEAT_W-1:0]          reads_left_q;
  logic                       rd_issue;
  logic                       rd_last;
  logic [AXIS_KEEP_WIDTH-1:0] rd_keep;
  logic                       credit_ok;

  // Read stage: RAM output register plus the beat attributes that travel
  // with it. rd_v_q marks a read in flight toward the queue.
  logic                       rd_v_q;
  logic                       rd_last_q;
  logic [AXIS_KEEP_WIDTH-1:0] rd_keep_q;
  logic [AXIS_DATA_WIDTH-1:0] rd_data_q;

  logic                       err_q;

  logic                       fifo_in_ready;
  logic                       fifo_pop;
  logic                       fifo_last;
  logic [1:0]                 fifo_count;

  // busy_o is high only while streaming: the DONE cycle already accepts
  // writes and a new send so frames can run back to back.
  assign busy        = (state_q == ST_STREAM);
  assign wr_en       = wr_v_i && !busy;
  assign len_ok      = (send_len_i != '0) && (send_len_i <= LEN_WIDTH'(MAX_BYTES));
  assign send_accept = send_v_i && !busy && len_ok;
  assign send_reject = send_v_i && (busy || !len_ok);

  assign beats_full  = (send_len_i + LEN_WIDTH'(AXIS_KEEP_WIDTH - 1)) / LEN_WIDTH'(AXIS_KEEP_WIDTH);
  assign beats_d     = BEAT_W'(beats_full);
  assign last_keep_d = AXIS_KEEP_WIDTH'(eth_tx_keep_f(32'(send_len_i), AXIS_KEEP_WIDTH));

  assign fifo_pop    = tx_axis_tvalid && tx_axis_tready;

  // Read credit: a read may start when the beats already queued plus the
  // one in flight, less the beat leaving this cycle, leave room in the
  // 2-entry queue. Counting the departing beat keeps full rate.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, rd_v_q}) < (3'd2 + {2'b00, fifo_pop});

  // Beat 0 is read in the accepting cycle itself, which is what gives
  // tvalid two cycles after the command.
  always_comb begin
    rd_issue = 1'b0;
    rd_addr  = rd_addr_q;
    rd_last  = 1'b0;
    rd_keep  = '1;
    if (send_accept) begin
      rd_issue = 1'b1;
      rd_addr  = '0;
      rd_last  = (beats_d == BEAT_W'(1));
      rd_keep  = rd_last ? last_keep_d : '1;
    end else if (state_q == ST_STREAM && reads_left_q != '0 && credit_ok) begin
      rd_issue = 1'b1;
      rd_addr  = rd_addr_q;
      rd_last  = (reads_left_q == BEAT_W'(1));
      rd_keep  = rd_last ? last_keep_q : '1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (send_accept) state_d = ST_STREAM;
      ST_STREAM: if (fifo_pop && fifo_last) state_d = ST_DONE;
      ST_DONE:   state_d = send_accept ? ST_STREAM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      reads_left_q <= '0;
      last_keep_q  <= '0;
      rd_v_q       <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_keep_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= send_reject;
      rd_v_q  <= rd_issue;
      if (rd_issue) begin
        rd_addr_q <= rd_addr + ADDR_WIDTH'(1);
        rd_last_q <= rd_last;
        rd_keep_q <= rd_keep;
      end
      if (send_accept) begin
        last_keep_q  <= last_keep_d;
        reads_left_q <= beats_d - BEAT_W'(1);
      end else if (rd_issue) begin
        reads_left_q <= reads_left_q - BEAT_W'(1);
      end
    end
  end

  // Frame buffer: 1R1W synchronous RAM, contents not reset. A write and
  // an accepted send in the same cycle both touch the RAM on one edge, so
  // a same-address read takes the incoming write data.
  always_ff @(posedge logic_clk) begin
    if (wr_en) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_issue) begin
      rd_data_q <= (wr_en && wr_addr_i == rd_addr) ? wr_data_i : mem[rd_addr];
    end
  end

  eth_tx_beat_fifo #(
    .DATA_W (AXIS_DATA_WIDTH),
    .KEEP_W (AXIS_KEEP_WIDTH)
  ) u_beat_fifo (
    .clk       (logic_clk),
    .rst       (logic_rst),
    .in_valid  (rd_v_q),
    .in_ready  (fifo_in_ready),
    .in_data   (rd_data_q),
    .in_keep   (rd_keep_q),
    .in_last   (rd_last_q),
    .out_valid (tx_axis_tvalid),
    .out_ready (tx_axis_tready),
    .out_data  (tx_axis_tdata),
    .out_keep  (tx_axis_tkeep),
    .out_last  (fifo_last),
    .count     (fifo_count)
  );

  // The credit scheme must never land a read on a full queue.
  a_no_overflow : assert property (@(posedge logic_clk) disable iff (logic_rst)
    rd_v_q |-> fifo_in_ready);

  assign tx_axis_tlast = fifo_last;
  assign tx_axis_tuser = 1'b0;
  assign busy_o        = busy;
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_eth_tx_frame_sender.sv
module tb_eth_tx_frame_sender;

  localparam int DW   = 32;
  localparam int KW   = 4;
  localparam int BW   = 512;
  localparam int AW   = 9;
  localparam int LW   = 12;

  // ---------------- clock / reset ----------------
  logic logic_clk = 1'b0;
  logic logic_rst;
  always #5 logic_clk = ~logic_clk;

  logic          wr_v_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          send_v_i;
  logic [LW-1:0] send_len_i;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] tx_axis_tdata;
  logic [KW-1:0] tx_axis_tkeep;
  logic          tx_axis_tvalid, tx_axis_tready, tx_axis_tlast, tx_axis_tuser;

  eth_tx_frame_sender dut (
    .logic_clk      (logic_clk),
    .logic_rst      (logic_rst),
    .wr_v_i         (wr_v_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .send_v_i       (send_v_i),
    .send_len_i     (send_len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .tx_axis_tdata  (tx_axis_tdata),
    .tx_axis_tkeep  (tx_axis_tkeep),
    .tx_axis_tvalid (tx_axis_tvalid),
    .tx_axis_tready (tx_axis_tready),
    .tx_axis_tlast  (tx_axis_tlast),
    .tx_axis_tuser  (tx_axis_tuser)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge logic_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Buffer model and scoreboard: {tlast, tkeep, tdata} per expected beat.
  logic [DW-1:0]   model [BW];
  logic [KW+DW:0]  exp_q [$];

  // ---------------- tready driver ----------------
  int rmode = 0;  // 0: always ready, 1: 1,0,0 pattern, 2: random
  initial begin
    int phase;
    phase = 0;
    tx_axis_tready = 1'b1;
    forever begin
      @(posedge logic_clk);
      #1;
      case (rmode)
        0:       tx_axis_tready = 1'b1;
        1:       tx_axis_tready = (phase % 3 == 0);
        default: tx_axis_tready = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  // ---------------- output monitor ----------------
  int             hs_count    = 0;
  int             last_hs_cyc = -10;
  int             bubbles     = 0;
  int             stall_viol  = 0;
  logic [KW-1:0]  last_keep_seen = '0;
  bit             in_frame    = 0;
  bit             prev_stall  = 0;
  logic [KW+DW:0] prev_beat   = '0;

  always @(negedge logic_clk) begin
    logic [KW+DW:0] cur;
    logic [KW+DW:0] e;
    cur = {tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata};
    if (logic_rst) begin
      exp_q.delete();
      in_frame   = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall && !(tx_axis_tvalid && cur == prev_beat)) stall_viol++;
      if (in_frame && !tx_axis_tvalid) bubbles++;
      if (tx_axis_tvalid && tx_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat (t=%0t)", cur, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 64'({tx_axis_tuser, cur}), 64'({1'b0, e}));
        end
        hs_count++;
        if (tx_axis_tlast) begin
          in_frame       = 0;
          last_hs_cyc    = cyc;
          last_keep_seen = tx_axis_tkeep;
        end else begin
          in_frame = 1;
        end
      end
      prev_stall = tx_axis_tvalid && !tx_axis_tready;
      prev_beat  = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int len);
    int beats, rem;
    logic [KW-1:0] k;
    beats = (len + KW - 1) / KW;
    rem   = len % KW;
    for (int b = 0; b < beats; b++) begin
      k = 4'hF;
      if (b == beats - 1 && rem != 0) k = 4'hF >> (KW - rem);
      exp_q.push_back({(b == beats - 1), k, model[b]});
    end
  endtask

  // Drives a one-cycle send; with now=1 it drives in the current cycle.
  task automatic send(input int len, input bit now, input bit good);
    if (!now) begin
      @(posedge logic_clk);
      #1;
    end
    send_v_i   = 1'b1;
    send_len_i = LW'(len);
    if (good) push_frame(len);
    @(posedge logic_clk);
    #1;
    send_v_i = 1'b0;
  endtask

  // Returns positioned just after the negedge of the done_o cycle.
  task automatic wait_done(input int budget);
    bit got;
    got = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge logic_clk);
      #1;
      if (done_o) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    if (got) chk("done_after_tlast", 64'(cyc), 64'(last_hs_cyc + 1));
  endtask

  task automatic after_done(input int b0, input int s0);
    @(negedge logic_clk);
    #1;
    chk("done_one_cycle", 64'(done_o), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("no_bubbles", 64'(bubbles - b0), 64'(0));
    chk("stall_stable", 64'(stall_viol - s0), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},   64'(busy_o), 64'(0));
    chk({tag, "_done"},   64'(done_o), 64'(0));
    chk({tag, "_err"},    64'(err_o), 64'(0));
    chk({tag, "_tvalid"}, 64'(tx_axis_tvalid), 64'(0));
    chk({tag, "_tlast"},  64'(tx_axis_tlast), 64'(0));
    chk({tag, "_tkeep"},  64'(tx_axis_tkeep), 64'(0));
    chk({tag, "_tdata"},  64'(tx_axis_tdata), 64'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            len;
    int            rmode;
    bit            bad;
    int            exp_beats;
    logic [KW-1:0] exp_last_keep;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int b0, s0, h0;
    rmode = v.rmode;
    b0 = bubbles;
    s0 = stall_viol;
    h0 = hs_count;
    if (v.bad) begin
      send(v.len, 0, 0);
      @(negedge logic_clk);
      #1;
      chk("reject_err_pulse", 64'(err_o), 64'(1));
      chk("reject_not_busy", 64'(busy_o), 64'(0));
      @(negedge logic_clk);
      #1;
      chk("reject_err_clear", 64'(err_o), 64'(0));
      chk("reject_no_beats", 64'(hs_count - h0), 64'(0));
    end else begin
      send(v.len, 0, 1);
      wait_done(v.len + 100);
      chk("vec_beats", 64'(hs_count - h0), 64'(v.exp_beats));
      chk("vec_last_keep", 64'(last_keep_seen), 64'(v.exp_last_keep));
      after_done(b0, s0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[12];
    int   b0, s0, h0;
    bit   reached;

    vecs[0]  = '{3,    0, 0, 1,   4'h7};
    vecs[1]  = '{64,   0, 0, 16,  4'hF};
    vecs[2]  = '{10,   1, 0, 3,   4'h3};
    vecs[3]  = '{0,    0, 1, 0,   4'h0};
    vecs[4]  = '{2049, 0, 1, 0,   4'h0};
    vecs[5]  = '{4095, 0, 1, 0,   4'h0};
    vecs[6]  = '{1,    2, 0, 1,   4'h1};
    vecs[7]  = '{2048, 2, 0, 512, 4'hF};
    vecs[8]  = '{5,    1, 0, 2,   4'h1};
    vecs[9]  = '{37,   2, 0, 10,  4'h1};
    vecs[10] = '{4,    0, 0, 1,   4'hF};
    vecs[11] = '{2047, 1, 0, 512, 4'h7};

    logic_rst  = 1'b1;
    wr_v_i     = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    send_v_i   = 1'b0;
    send_len_i = '0;

    // Reset values
    repeat (2) @(posedge logic_clk);
    @(negedge logic_clk);
    #1;
    check_outputs_zero("reset");
    @(posedge logic_clk);
    #1;
    logic_rst = 1'b0;

    // Fill the whole buffer with random words
    for (int i = 0; i < BW; i++) begin
      @(posedge logic_clk);
      #1;
      wr_v_i    = 1'b1;
      wr_addr_i = AW'(i);
      wr_data_i = $urandom();
      model[i]  = wr_data_i;
    end
    @(posedge logic_clk);
    #1;
    wr_v_i = 1'b0;

    // Single beat with latency checks
    rmode = 0;
    @(posedge logic_clk);
    #1;
    wr_v_i    = 1'b1;
    wr_addr_i = '0;
    wr_data_i = 32'h44332211;
    model[0]  = 32'h44332211;
    @(posedge logic_clk);
    #1;
    wr_v_i = 1'b0;
    b0 = bubbles;
    s0 = stall_viol;
    send(3, 0, 1);
    @(negedge logic_clk);
    #1;
    chk("lat_c1_busy", 64'(busy_o), 64'(1));
    chk("lat_c1_tvalid", 64'(tx_axis_tvalid), 64'(0));
    @(negedge logic_clk);
    #1;
    chk("lat_c2_tvalid", 64'(tx_axis_tvalid), 64'(1));
    chk("single_tdata", 64'(tx_axis_tdata), 64'(32'h44332211));
    chk("single_tkeep", 64'(tx_axis_tkeep), 64'(4'h7));
    chk("single_tlast", 64'(tx_axis_tlast), 64'(1));
    wait_done(20);
    after_done(b0, s0);

    // Write and send in the same idle cycle: the new word must go out
    @(posedge logic_clk);
    #1;
    wr_v_i     = 1'b1;
    wr_addr_i  = '0;
    wr_data_i  = 32'hA5A50F0F;
    model[0]   = 32'hA5A50F0F;
    send_v_i   = 1'b1;
    send_len_i = LW'(4);
    push_frame(4);
    @(posedge logic_clk);
    #1;
    wr_v_i   = 1'b0;
    send_v_i = 1'b0;
    wait_done(20);
    after_done(b0, s0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Write protection, send while busy, back-to-back via the DONE cycle
    rmode = 1;
    b0 = bubbles;
    s0 = stall_viol;
    send(64, 0, 1);
    repeat (4) @(posedge logic_clk);
    #1;
    wr_v_i     = 1'b1;
    wr_addr_i  = AW'(3);
    wr_data_i  = ~model[3];
    send_v_i   = 1'b1;
    send_len_i = LW'(8);
    @(posedge logic_clk);
    #1;
    wr_v_i   = 1'b0;
    send_v_i = 1'b0;
    @(negedge logic_clk);
    #1;
    chk("busy_send_err", 64'(err_o), 64'(1));
    chk("busy_send_still_busy", 64'(busy_o), 64'(1));
    wait_done(300);
    chk("busy_low_in_done", 64'(busy_o), 64'(0));
    send(64, 1, 1);
    @(negedge logic_clk);
    #1;
    chk("b2b_busy", 64'(busy_o), 64'(1));
    chk("b2b_no_err", 64'(err_o), 64'(0));
    wait_done(300);
    after_done(b0, s0);

    // Reset in the middle of a frame
    rmode = 0;
    h0 = hs_count;
    send(64, 0, 1);
    reached = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge logic_clk);
      #2;
      if (hs_count - h0 >= 5) begin
        reached = 1;
        break;
      end
    end
    chk("midframe_reached_beat5", 64'(reached), 64'(1));
    @(posedge logic_clk);
    #1;
    logic_rst = 1'b1;
    @(posedge logic_clk);
    @(negedge logic_clk);
    #1;
    check_outputs_zero("midrst");
    @(posedge logic_clk);
    #1;
    logic_rst = 1'b0;
    b0 = bubbles;
    s0 = stall_viol;
    h0 = hs_count;
    rmode = 2;
    send(20, 0, 1);
    wait_done(100);
    chk("post_rst_beats", 64'(hs_count - h0), 64'(5));
    after_done(b0, s0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
